// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority voting at mid-bit.
// Produces one-cycle received/recv_error pulses and holds the last good byte.
module uart_byte_rx #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       received,
  output logic       is_receiving,
  output logic       recv_error
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic             rx_s1_q, rx_s1_d;
  logic             rx_s2_q, rx_s2_d;
  logic             rx_prev_q, rx_prev_d;
  logic [1:0]       sync_fill_q, sync_fill_d;
  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       s_q, s_d;
  logic [3:0]       b_q, b_d;
  logic [1:0]       samp_q, samp_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             received_q, received_d;
  logic             recv_error_q, recv_error_d;

  logic running;
  logic tick;
  logic decide;
  logic bit_val;

  assign running = (state_q == START) || (state_q == DATA) || (state_q == STOP);
  assign tick    = running && (div_q == DIV_LAST);
  assign decide  = tick && (s_q == 4'd9);
  assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s2_q) | (samp_q[1] & rx_s2_q);

  always_comb begin
    rx_s1_d      = rx;
    rx_s2_d      = rx_s1_q;
    sync_fill_d  = {sync_fill_q[0], 1'b1};
    // The synchronizer's reset value of 1 is not a real observation of the
    // line, so the edge detector only trusts rx_s2 once it carries sampled data.
    rx_prev_d    = sync_fill_q[1] ? rx_s2_q : 1'b0;
    state_d      = state_q;
    div_d        = div_q;
    s_d          = s_q;
    b_d          = b_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    rx_byte_d    = rx_byte_q;
    received_d   = 1'b0;
    recv_error_d = 1'b0;

    if (running) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        s_d = s_q + 4'd1;
        if (s_q == 4'd15) b_d = b_q + 4'd1;
        if (s_q == 4'd7) samp_d[0] = rx_s2_q;
        if (s_q == 4'd8) samp_d[1] = rx_s2_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          state_d = START;
          div_d   = '0;
          s_d     = '0;
          b_d     = '0;
          samp_d  = '0;
        end
      end
      START: begin
        if (decide) state_d = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (decide) begin
          shift_d = {bit_val, shift_q[7:1]};
          if (b_q == 4'd8) state_d = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop-bit so a back-to-back start edge is not missed.
        if (decide) begin
          if (bit_val) begin
            rx_byte_d  = shift_q;
            received_d = 1'b1;
            state_d    = IDLE;
          end else begin
            recv_error_d = 1'b1;
            state_d      = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b0;
      sync_fill_q  <= 2'b00;
      state_q      <= IDLE;
      div_q        <= '0;
      s_q          <= '0;
      b_q          <= '0;
      samp_q       <= '0;
      shift_q      <= '0;
      rx_byte_q    <= '0;
      received_q   <= 1'b0;
      recv_error_q <= 1'b0;
    end else begin
      rx_s1_q      <= rx_s1_d;
      rx_s2_q      <= rx_s2_d;
      rx_prev_q    <= rx_prev_d;
      sync_fill_q  <= sync_fill_d;
      state_q      <= state_d;
      div_q        <= div_d;
      s_q          <= s_d;
      b_q          <= b_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      rx_byte_q    <= rx_byte_d;
      received_q   <= received_d;
      recv_error_q <= recv_error_d;
    end
  end

  assign rx_byte      = rx_byte_q;
  assign received     = received_q;
  assign recv_error   = recv_error_q;
  assign is_receiving = (state_q == START) || (state_q == DATA) ||
                        (state_q == STOP)  || (state_q == WAIT_HIGH);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: drives 8N1 frames on rx and checks received bytes
// against a queue of expected values, plus error pulses and busy timing.
module tb_uart_byte_rx;

  // Scaled clock keeps the run short: DIV = 8, 128 clocks per bit.
  localparam int CLK_FREQ  = 1228800;
  localparam int BAUD      = 9600;
  localparam int DIV       = 8;
  localparam int BIT_CYC   = 16 * DIV;
  localparam int FRAME_LEN = DIV * 154;
  localparam int FAST_CYC  = 124;
  localparam int SLOW_CYC  = 132;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_byte;
  logic       received;
  logic       is_receiving;
  logic       recv_error;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  int recv_count = 0;
  int err_count = 0;
  int rise_count = 0;
  int busy_len = 0;
  int last_busy_len = 0;
  logic busy_prev = 1'b0;

  uart_byte_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .OVERSAMPLE(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .rx_byte(rx_byte),
    .received(received),
    .is_receiving(is_receiving),
    .recv_error(recv_error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one frame on rx at negedges; cycle 0 is the start-bit falling edge.
  // max_cycles > 0 truncates the frame; glitch inverts rx for one cycle at
  // the s=8 sample point of every bit.
  task automatic applyStimulus(input logic [7:0] data, input int bit_cyc,
                               input logic stop_val, input logic glitch,
                               input int max_cycles);
    logic [9:0] frame;
    int total;
    int bitn;
    logic v;
    frame = {stop_val, data, 1'b0};
    total = (max_cycles > 0) ? max_cycles : 10 * bit_cyc;
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      bitn = i / bit_cyc;
      v = frame[bitn];
      if (glitch && (i == DIV * (16 * bitn + 9))) v = ~v;
      rx = v;
    end
  endtask

  // Scoreboard and pulse/busy monitor
  always @(negedge clk) begin
    if (received) begin
      recv_count++;
      checkOutput("pulse_exclusive_rx", recv_error, 1'b0);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_received observed=%02h expected=none", rx_byte);
      end
      if (exp_q.size() != 0) checkOutput("scoreboard_byte", rx_byte, exp_q.pop_front());
    end
    if (recv_error) begin
      err_count++;
      checkOutput("pulse_exclusive_err", received, 1'b0);
    end
    if (is_receiving && !busy_prev) rise_count++;
    if (is_receiving) busy_len++;
    else if (busy_len != 0) begin
      last_busy_len = busy_len;
      busy_len = 0;
    end
    busy_prev = is_receiving;
  end

  initial begin
    int r0;
    int c0;
    $display("[TB] start");

    // Reset values
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("reset_rx_byte", rx_byte, 8'h00);
    checkOutput("reset_received", received, 1'b0);
    checkOutput("reset_recv_error", recv_error, 1'b0);
    checkOutput("reset_is_receiving", is_receiving, 1'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Good byte
    exp_q.push_back(8'h55);
    applyStimulus(8'h55, BIT_CYC, 1'b1, 1'b0, 0);
    repeat (20) @(negedge clk);
    checkOutput("good_count", recv_count, 1);
    checkOutput("good_no_error", err_count, 0);
    checkOutput("good_busy_len", last_busy_len, FRAME_LEN);
    checkOutput("good_byte", rx_byte, 8'h55);

    // Back-to-back frames, no idle gap
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    applyStimulus(8'h00, BIT_CYC, 1'b1, 1'b0, 0);
    applyStimulus(8'hFF, BIT_CYC, 1'b1, 1'b0, 0);
    repeat (20) @(negedge clk);
    checkOutput("b2b_count", recv_count, 3);
    checkOutput("b2b_last_byte", rx_byte, 8'hFF);

    // False start: short low pulse well before the start-bit samples
    r0 = rise_count;
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("false_start_rise", rise_count, r0 + 1);
    checkOutput("false_start_busy_len", last_busy_len, DIV * 10);
    checkOutput("false_start_no_rx", recv_count, 3);
    checkOutput("false_start_no_err", err_count, 0);
    checkOutput("false_start_idle", is_receiving, 1'b0);

    // Framing error followed by a long break
    exp_q.push_back(8'h3C);
    applyStimulus(8'h3C, BIT_CYC, 1'b1, 1'b0, 0);
    applyStimulus(8'hA5, BIT_CYC, 1'b0, 1'b0, 0);
    rx = 1'b0;
    repeat (40000) @(negedge clk);
    checkOutput("frame_err_count", err_count, 1);
    checkOutput("frame_err_byte_held", rx_byte, 8'h3C);
    checkOutput("frame_err_wait_high", is_receiving, 1'b1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("frame_err_released", is_receiving, 1'b0);
    exp_q.push_back(8'h3C);
    applyStimulus(8'h3C, BIT_CYC, 1'b1, 1'b0, 0);
    repeat (20) @(negedge clk);
    checkOutput("frame_err_recover_count", recv_count, 5);
    checkOutput("frame_err_single", err_count, 1);

    // Glitches at every s=8 sample, then +/-3% baud
    exp_q.push_back(8'hC3);
    applyStimulus(8'hC3, BIT_CYC, 1'b1, 1'b1, 0);
    repeat (20) @(negedge clk);
    exp_q.push_back(8'h96);
    applyStimulus(8'h96, FAST_CYC, 1'b1, 1'b0, 0);
    repeat (20) @(negedge clk);
    exp_q.push_back(8'h96);
    applyStimulus(8'h96, SLOW_CYC, 1'b1, 1'b0, 0);
    repeat (20) @(negedge clk);
    checkOutput("glitch_baud_count", recv_count, 8);
    checkOutput("glitch_baud_no_err", err_count, 1);

    // Reset in the middle of bit 4 of 0x81 (line is low there)
    c0 = recv_count;
    applyStimulus(8'h81, BIT_CYC, 1'b1, 1'b0, BIT_CYC * 4 + BIT_CYC / 2);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midreset_rx_byte", rx_byte, 8'h00);
    checkOutput("midreset_received", received, 1'b0);
    checkOutput("midreset_recv_error", recv_error, 1'b0);
    checkOutput("midreset_is_receiving", is_receiving, 1'b0);
    r0 = rise_count;
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    checkOutput("low_release_no_start", rise_count, r0);
    checkOutput("low_release_idle", is_receiving, 1'b0);
    rx = 1'b1;
    repeat (50) @(negedge clk);
    checkOutput("high_no_start", rise_count, r0);
    exp_q.push_back(8'h81);
    applyStimulus(8'h81, BIT_CYC, 1'b1, 1'b0, 0);
    repeat (20) @(negedge clk);
    checkOutput("after_reset_count", recv_count, c0 + 1);
    checkOutput("after_reset_byte", rx_byte, 8'h81);
    checkOutput("after_reset_no_err", err_count, 1);

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
